// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder and the processor data path.
package dmem_pkg;

  // Default widths shared with the processor data path.
  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 12;

  // Widest wait-state count the down-counter can hold.
  localparam int DMEM_MAX_WAIT = 15;

  // Responder control states.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmemState_e;

endpackage

// File: rtl/dmem_storage.sv
// Word storage: one synchronous write port and one synchronous registered
// read port. The array and the read register carry no reset; the owner
// clears the array and qualifies the read register.
module dmem_storage #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [IDX_W-1:0]  rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store one word when enabled.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Read port: capture the addressed word when enabled, hold otherwise.
  always_ff @(posedge clk) begin
    if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder with programmable wait states. After reset it
// clears every storage word, then serves single load/store requests from
// the processor data path.
//
// Request/response protocol: memRead and memWrite are level requests.
// A request is accepted on a rising edge where the block is not busy and
// exactly one of them is high; address, writeData and the request type
// are captured at that edge and later input changes do not affect the
// access. Completion is a single-cycle ready pulse WAIT_CYCLES+1 cycles
// after the accept cycle; for loads readData is valid from that pulse and
// holds until the next load completes. Both requests high while idle is
// rejected with a single-cycle err pulse and no access. busy is low only
// when a request can be accepted at the next edge.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // Control state; kept as a named enum so checkers can bind to it.
  dmemState_e state;
  dmemState_e nextState;

  logic [IDX_W-1:0]  initIdx;
  logic [3:0]        waitCnt;
  logic [IDX_W-1:0]  reqIdx;
  logic [DATA_W-1:0] reqData;
  logic              reqWrite;
  logic              errPulse;
  logic              readValid;

  logic              acceptReq;
  logic              illegalReq;
  logic              commit;
  logic [IDX_W-1:0]  commitIdx;
  logic [DATA_W-1:0] commitData;
  logic              commitWrite;

  logic              wrEn;
  logic [IDX_W-1:0]  wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              rdEn;
  logic [DATA_W-1:0] rdData;

  // Address bits above the storage index are ignored by design.
  generate
    if (ADDR_W > IDX_W) begin : gUpperAddr
      logic unusedAddrHi;
      assign unusedAddrHi = ^address[ADDR_W-1:IDX_W];
    end
  endgenerate

  // Next-state decode plus accept/reject/commit strobes.
  always_comb begin
    nextState  = state;
    acceptReq  = 1'b0;
    illegalReq = 1'b0;
    commit     = 1'b0;
    unique case (state)
      INIT: begin
        if (initIdx == IDX_W'(DEPTH - 1)) begin
          nextState = IDLE;
        end
      end
      IDLE: begin
        if (memRead ^ memWrite) begin
          acceptReq = 1'b1;
          if (WAIT_CYCLES == 0) begin
            nextState = RESP;
            commit    = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end else if (memRead & memWrite) begin
          illegalReq = 1'b1;
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) begin
          nextState = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        nextState = IDLE;
      end
      default: begin
        nextState = INIT;
      end
    endcase
  end

  // Commit operands: straight from the inputs when committing on the accept
  // edge (no wait states), otherwise from the captured request.
  always_comb begin
    commitIdx   = reqIdx;
    commitData  = reqData;
    commitWrite = reqWrite;
    if (state == IDLE) begin
      commitIdx   = address[IDX_W-1:0];
      commitData  = writeData;
      commitWrite = memWrite;
    end
  end

  // Storage port steering; nothing reaches storage on a reset edge so an
  // aborted access never commits.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = commitIdx;
    wrData = commitData;
    rdEn   = 1'b0;
    if (!rst) begin
      if (state == INIT) begin
        wrEn   = 1'b1;
        wrAddr = initIdx;
        wrData = '0;
      end else if (commit) begin
        wrEn = commitWrite;
        rdEn = ~commitWrite;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= nextState;
    end
  end

  // Clear index, wait counter, captured request and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      initIdx   <= '0;
      waitCnt   <= 4'd0;
      reqIdx    <= '0;
      reqData   <= '0;
      reqWrite  <= 1'b0;
      errPulse  <= 1'b0;
      readValid <= 1'b0;
    end else begin
      errPulse <= illegalReq;
      if (state == INIT) begin
        initIdx <= initIdx + 1'b1;
      end
      if (acceptReq) begin
        reqIdx   <= address[IDX_W-1:0];
        reqData  <= writeData;
        reqWrite <= memWrite;
        waitCnt  <= WAIT_LOAD;
      end else if ((state == WAIT) && (waitCnt != 4'd0)) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (rdEn) begin
        readValid <= 1'b1;
      end
    end
  end

  dmem_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uStorage (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdEn   (rdEn),
    .rdAddr (commitIdx),
    .rdData (rdData)
  );

  // The storage read register has no reset, so readData reads as zero
  // until the first load after reset has completed.
  assign readData = readValid ? rdData : '0;
  assign ready    = (state == RESP);
  assign busy     = (state != IDLE);
  assign err      = errPulse;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states and 256
// words, one with zero wait states and 16 words.
module tb_data_mem_responder;

  localparam int DEPTH  = 256;
  localparam int DEPTH0 = 16;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, memRead, memWrite, ready, busy, err;
  logic [11:0] address;
  logic [15:0] writeData, readData;
  logic        rst0, memRead0, memWrite0, ready0, busy0, err0;
  logic [11:0] address0;
  logic [15:0] writeData0, readData0;

  data_mem_responder #(
    .DATA_W(16), .ADDR_W(12), .DEPTH(DEPTH), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .readData(readData),
    .ready(ready), .busy(busy), .err(err)
  );

  data_mem_responder #(
    .DATA_W(16), .ADDR_W(12), .DEPTH(DEPTH0), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst0), .memRead(memRead0), .memWrite(memWrite0),
    .address(address0), .writeData(writeData0), .readData(readData0),
    .ready(ready0), .busy(busy0), .err(err0)
  );

  // Scoreboard state: expected readData per ready pulse, plus memory models.
  logic [15:0] exp_q[$];
  logic [15:0] exp0_q[$];
  logic [15:0] model  [DEPTH];
  logic [15:0] model0 [DEPTH0];
  logic [15:0] lastRead, lastRead0;
  logic [15:0] expW, expW0;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pops on every ready pulse.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("dut unexpected ready", 32'd1, 32'd0);
      end else begin
        expW = exp_q.pop_front();
        check("dut readData", 32'(readData), 32'(expW));
      end
    end
    if (ready0 === 1'b1) begin
      if (exp0_q.size() == 0) begin
        check("dut0 unexpected ready", 32'd1, 32'd0);
      end else begin
        expW0 = exp0_q.pop_front();
        check("dut0 readData", 32'(readData0), 32'(expW0));
      end
    end
  end

  // Driver tasks.
  task automatic waitIdle(input bit sel, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((sel ? busy0 : busy) !== 1'b0) && (n < 1000));
    check({tag, " idle"}, 32'(sel ? busy0 : busy), 32'd0);
  endtask

  task automatic waitReady(input bit sel, input int expLat, input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && (n < 40)) begin
      @(negedge clk);
      n++;
      if ((sel ? ready0 : ready) === 1'b1) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(n), 32'(expLat));
  endtask

  task automatic issue(input bit sel, input bit isWr, input logic [11:0] addr,
                       input logic [15:0] data, input int expLat, input string tag);
    waitIdle(sel, tag);
    if (sel) begin
      memRead0 = ~isWr; memWrite0 = isWr; address0 = addr; writeData0 = data;
      if (isWr) model0[addr[3:0]] = data;
      else lastRead0 = model0[addr[3:0]];
      exp0_q.push_back(lastRead0);
    end else begin
      memRead = ~isWr; memWrite = isWr; address = addr; writeData = data;
      if (isWr) model[addr[7:0]] = data;
      else lastRead = model[addr[7:0]];
      exp_q.push_back(lastRead);
    end
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0; memRead0 = 1'b0; memWrite0 = 1'b0;
    waitReady(sel, expLat, tag);
  endtask

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int busyCnt;
    int readyCnt;
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; writeData = '0;
    rst0 = 1'b1; memRead0 = 1'b0; memWrite0 = 1'b0; address0 = '0; writeData0 = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH0; i++) model0[i] = '0;
    lastRead = '0; lastRead0 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd1);
    check("reset ready", 32'(ready), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset readData", 32'(readData), 32'd0);
    check("reset busy0", 32'(busy0), 32'd1);

    // Read request held through the whole clear sequence.
    memRead = 1'b1; address = 12'h005;
    @(posedge clk); #1;
    rst = 1'b0; rst0 = 1'b0;
    busyCnt = 0;
    @(negedge clk);
    while ((busy === 1'b1) && (busyCnt < 1000)) begin
      busyCnt++;
      @(negedge clk);
    end
    check("init busy cycles", 32'(busyCnt), 32'd256);
    lastRead = model[8'h05];
    exp_q.push_back(lastRead);
    @(posedge clk); #1;
    memRead = 1'b0;
    waitReady(0, 3, "init read");

    // Store then load at the same address.
    issue(0, 1'b1, 12'h010, 16'h1234, 3, "wr 010");
    issue(0, 1'b0, 12'h010, 16'h0000, 3, "rd 010");

    // Upper address bits wrap onto the same word.
    issue(0, 1'b1, 12'h110, 16'hBEEF, 3, "wr 110");
    issue(0, 1'b0, 12'h010, 16'h0000, 3, "rd wrap");

    // Both requests together: rejected, no access.
    waitIdle(0, "illegal");
    memRead = 1'b1; memWrite = 1'b1; address = 12'h010; writeData = 16'h5555;
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    @(negedge clk);
    check("illegal err", 32'(err), 32'd1);
    check("illegal ready", 32'(ready), 32'd0);
    check("illegal busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("illegal err one cycle", 32'(err), 32'd0);
    check("illegal ready later", 32'(ready), 32'd0);
    issue(0, 1'b0, 12'h010, 16'h0000, 3, "rd after illegal");

    // Random loads and stores against the model.
    for (int i = 0; i < 12; i++) begin
      issue(0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
            16'($urandom_range(0, 65535)), 3, "rand");
    end

    // Reset on the edge that would have committed a store.
    waitIdle(0, "abort");
    memWrite = 1'b1; address = 12'h020; writeData = 16'hAAAA;
    @(posedge clk); #1;
    memWrite = 1'b0;
    @(negedge clk);
    check("abort in wait busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort readData cleared", 32'(readData), 32'd0);
    check("abort ready", 32'(ready), 32'd0);
    busyCnt = 0;
    readyCnt = 0;
    while ((busy === 1'b1) && (busyCnt < 1000)) begin
      busyCnt++;
      if (ready === 1'b1) readyCnt++;
      @(negedge clk);
    end
    check("abort init cycles", 32'(busyCnt), 32'd256);
    check("abort no ready", 32'(readyCnt), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    lastRead = '0;
    issue(0, 1'b0, 12'h020, 16'h0000, 3, "rd aborted");
    issue(0, 1'b0, 12'h010, 16'h0000, 3, "rd cleared");

    // Zero wait states: stores, then back-to-back loads.
    issue(1, 1'b1, 12'h001, 16'h0A01, 1, "w0 wr 1");
    issue(1, 1'b1, 12'h002, 16'h0B02, 1, "w0 wr 2");
    waitIdle(1, "w0 b2b");
    memRead0 = 1'b1; address0 = 12'h001;
    lastRead0 = model0[4'h1];
    exp0_q.push_back(lastRead0);
    @(posedge clk); #1;
    address0 = 12'h002;
    lastRead0 = model0[4'h2];
    exp0_q.push_back(lastRead0);
    @(negedge clk);
    check("w0 b2b first ready", 32'(ready0), 32'd1);
    check("w0 b2b first data", 32'(readData0), 32'h0A01);
    @(negedge clk);
    check("w0 b2b gap ready", 32'(ready0), 32'd0);
    check("w0 b2b gap busy", 32'(busy0), 32'd0);
    @(posedge clk); #1;
    memRead0 = 1'b0;
    @(negedge clk);
    check("w0 b2b second ready", 32'(ready0), 32'd1);
    check("w0 b2b second data", 32'(readData0), 32'h0B02);
    @(negedge clk);
    check("w0 b2b done", 32'(ready0), 32'd0);

    // Every expected response must have been consumed.
    repeat (4) @(negedge clk);
    check("dut queue drained", 32'(exp_q.size()), 32'd0);
    check("dut0 queue drained", 32'(exp0_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 12, request address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of storage words (power of two, <= 2**ADDR_W).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, wait states per access (0..15).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port memRead  input  1  read request, level, from the processor data path.
REQ-008 SHALL have port memWrite  input  1  write request, level, from the processor data path.
REQ-009 SHALL have port address  input  ADDR_W  word address of the request.
REQ-010 SHALL have port writeData  input  DATA_W  store data.
REQ-011 SHALL have port readData  output  DATA_W  registered load data.
REQ-012 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high whenever a new request cannot be accepted.
REQ-014 SHALL have port err  output  1  one-cycle pulse on an illegal request.

Function
REQ-015 SHALL implement states INIT, IDLE, WAIT, RESP, with all outputs decoded from registered state or registers only.
REQ-016 INIT SHALL write zero to one word per cycle, index 0..DEPTH-1, then go to IDLE; busy=1 and requests are ignored in INIT.
REQ-017 In IDLE, exactly one of memRead/memWrite high at an edge SHALL accept the request and latch address, writeData and type at that edge.
REQ-018 On accept, the block SHALL go to RESP if WAIT_CYCLES=0, else to WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-019 WAIT SHALL go to RESP when the counter is 0, else decrement it; latched values are held, and input changes are ignored.
REQ-020 The edge entering RESP SHALL commit a write to storage, or load readData from storage for a read.
REQ-021 ready SHALL be 1 only in RESP, so that ready is high in the cycle after edge E0+WAIT_CYCLES, where E0 is the accept edge.
REQ-022 RESP SHALL last one cycle and then go to IDLE; a request still high in IDLE SHALL be accepted as a new access.
REQ-023 readData SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-024 The storage index SHALL be address modulo DEPTH; upper address bits are ignored without error.
REQ-025 memRead and memWrite both high in IDLE SHALL give no access, a one-cycle err pulse in the next cycle, and remain in IDLE.
REQ-026 busy SHALL be 0 only in IDLE.

Reset
REQ-027 rst high at an edge SHALL force state INIT with index 0, counter 0, readData 0, ready 0, err 0 and busy 1, from any state.
REQ-028 A rst arriving during WAIT SHALL abort the access: no write commit, and no ready pulse.
REQ-029 After rst is released, INIT SHALL take exactly DEPTH cycles before IDLE.

Structure
REQ-030 Package dmem_pkg SHALL hold the state enum (INIT, IDLE, WAIT, RESP) and the default DATA_W/ADDR_W constants shared with the processor data path.
REQ-031 The storage array SHALL be sub-module dmem_storage: one synchronous write port and one synchronous read port, no reset.

Verification
REQ-032 Release reset, then hold memRead at address 0x005 throughout INIT -> busy=1 for 256 cycles, then ready with readData=0x0000.
REQ-033 WAIT_CYCLES=2: write 0x1234 at address 0x010, then read address 0x010 -> each ready pulse occurs 3 cycles after the request cycle, and readData=0x1234.
REQ-034 Write 0xBEEF at address 0x110 (DEPTH=256), then read address 0x010 -> readData=0xBEEF (address wrap).
REQ-035 Assert memRead and memWrite together in IDLE -> err=1 for one cycle, ready stays 0, and the previously stored data is unchanged.
REQ-036 Assert rst in WAIT of a write of 0xAAAA -> no ready pulse; after INIT, a read of that address returns 0x0000.
REQ-037 WAIT_CYCLES=0: issue back-to-back reads of addresses 1 and 2 -> ready pulses are one cycle apart with IDLE between, and readData updates on each pulse.
